// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer: pulses PLL reset, qualifies lock, releases downstream reset, retries on failure.
// Optional status counters (loss_count, lock_time) are built when PLL_SUP_STATUS_EN is defined.
module pll_lock_supervisor #(
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 1000000,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int MAX_RETRIES         = 3,
   parameter int CNT_W               = 20
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             pll_locked,
   input  logic             relock_req,
   output logic             pll_rst,
   output logic             sys_rst_n,
   output logic             ready,
   output logic             fail,
   output logic [1:0]       retry_cnt,
   output logic             lock_lost
`ifdef PLL_SUP_STATUS_EN
   ,
   output logic [7:0]       loss_count,
   output logic [CNT_W-1:0] lock_time
`endif
);

   localparam int RC_W = (MAX_RETRIES < 4) ? 2 : $clog2(MAX_RETRIES + 1);
   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [RC_W-1:0]  RC_MAX   = RC_W'(MAX_RETRIES);

   typedef enum logic [2:0] {
      ST_RST_PLL,
      ST_WAIT_LOCK,
      ST_STABLE,
      ST_RUN,
      ST_FAIL
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  timer, timer_nxt;
   logic [RC_W-1:0]   attempts, attempts_nxt;
   logic              lk_p0, lk_p1, lk;
   logic              lost_nxt;

   function automatic logic [1:0] sat_retry(input logic [RC_W-1:0] n);
      if (n > RC_W'(3)) return 2'd3;
      return n[1:0];
   endfunction

   // pll_locked is asynchronous to clk: two-flop synchroniser
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lk_p0 <= 1'b0;
         lk_p1 <= 1'b0;
      end else begin
         lk_p0 <= pll_locked;
         lk_p1 <= lk_p0;
      end
   end

   assign lk = lk_p1;

   always_comb begin
      state_nxt    = state;
      timer_nxt    = timer;
      attempts_nxt = attempts;
      lost_nxt     = (state == ST_RUN) && !lk;
      if (relock_req) begin
         state_nxt    = ST_RST_PLL;
         timer_nxt    = '0;
         attempts_nxt = '0;
      end else begin
         case (state)
            ST_RST_PLL: begin
               if (timer == RST_LAST) begin
                  state_nxt = ST_WAIT_LOCK;
                  timer_nxt = '0;
               end else begin
                  timer_nxt = timer + CNT_W'(1);
               end
            end
            ST_WAIT_LOCK: begin
               if (lk) begin
                  state_nxt = ST_STABLE;
                  timer_nxt = '0;
               end else if (timer == TO_LAST) begin
                  attempts_nxt = attempts + RC_W'(1);
                  timer_nxt    = '0;
                  state_nxt    = (attempts_nxt == RC_MAX) ? ST_FAIL : ST_RST_PLL;
               end else begin
                  timer_nxt = timer + CNT_W'(1);
               end
            end
            // A lock glitch restarts qualification without charging a retry
            ST_STABLE: begin
               if (!lk) begin
                  timer_nxt = '0;
               end else if (timer == STB_LAST) begin
                  state_nxt    = ST_RUN;
                  timer_nxt    = '0;
                  attempts_nxt = '0;
               end else begin
                  timer_nxt = timer + CNT_W'(1);
               end
            end
            ST_RUN: begin
               if (!lk) begin
                  state_nxt = ST_RST_PLL;
                  timer_nxt = '0;
               end
            end
            ST_FAIL: begin
               state_nxt = ST_FAIL;
            end
            default: begin
               state_nxt = ST_RST_PLL;
               timer_nxt = '0;
            end
         endcase
      end
   end

   // Outputs are registered from the next state so they align with the state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_RST_PLL;
         timer     <= '0;
         attempts  <= '0;
         pll_rst   <= 1'b1;
         sys_rst_n <= 1'b0;
         ready     <= 1'b0;
         fail      <= 1'b0;
         retry_cnt <= 2'd0;
         lock_lost <= 1'b0;
      end else begin
         state     <= state_nxt;
         timer     <= timer_nxt;
         attempts  <= attempts_nxt;
         pll_rst   <= (state_nxt == ST_RST_PLL) || (state_nxt == ST_FAIL);
         sys_rst_n <= (state_nxt == ST_RUN);
         ready     <= (state_nxt == ST_RUN);
         fail      <= (state_nxt == ST_FAIL);
         retry_cnt <= sat_retry(attempts_nxt);
         lock_lost <= lost_nxt;
      end
   end

`ifdef PLL_SUP_STATUS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         loss_count <= 8'd0;
         lock_time  <= '0;
      end else begin
         if (lost_nxt && (loss_count != 8'hFF)) loss_count <= loss_count + 8'd1;
         if ((state == ST_WAIT_LOCK) && lk && !relock_req) lock_time <= timer;
      end
   end
`endif

endmodule
